// File: rtl/phase_pc_unit_if.sv
// Bus between the phase/PC unit and its surroundings: run control from the
// sequencer, PC writes from the PC-select stage, and the phase/PC status
// returned by the unit.
interface phase_pc_unit_if;
    logic        exec;
    logic        step;
    logic        halt_req;
    logic        load_en;
    logic [11:0] load_addr;
    logic [11:0] next_pc;
    logic        pc_enable;
    logic [4:0]  phase;
    logic [11:0] pc;
    logic [11:0] from_adder;
    logic        running;
    logic        instr_done;
    logic [15:0] instr_count;

    // Driver side: control and PC-select stage.
    modport master (
        output exec, step, halt_req, load_en, load_addr, next_pc, pc_enable,
        input  phase, pc, from_adder, running, instr_done, instr_count
    );

    // The phase/PC unit itself.
    modport slave (
        input  exec, step, halt_req, load_en, load_addr, next_pc, pc_enable,
        output phase, pc, from_adder, running, instr_done, instr_count
    );
endinterface

// File: rtl/phase_pc_unit.sv
// Five-phase instruction sequencer with program counter.
// IDLE waits for load/exec/step; RUN repeats P0..P4 until a halt is pending
// at the end of P4; STEP executes a single P0..P4 pass. The PC is written
// from the PC-select stage only at the end of P3.
module phase_pc_unit #(
    parameter logic [11:0] PC_RESET = 12'h000
) (
    input  logic            clk,
    input  logic            rst,
    phase_pc_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam logic [4:0] PH_NONE = 5'b00000;
    localparam logic [4:0] PH_P0   = 5'b00001;
    localparam logic [4:0] PH_P1   = 5'b00010;
    localparam logic [4:0] PH_P2   = 5'b00100;
    localparam logic [4:0] PH_P3   = 5'b01000;
    localparam logic [4:0] PH_P4   = 5'b10000;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  phase_r;
    logic [4:0]  phase_s;
    logic [11:0] pc_r;
    logic [11:0] pc_s;
    logic        halt_pending_r;
    logic        halt_pending_s;
    logic        halt_now_s;
    logic        instr_done_r;
    logic        instr_done_s;
    logic [15:0] instr_count_r;
    logic [15:0] instr_count_s;
    logic        running_r;
    logic        running_s;

    // Next-state and next-datapath values for the sequencer.
    always_comb begin
        state_s        = state_r;
        phase_s        = phase_r;
        pc_s           = pc_r;
        halt_pending_s = halt_pending_r;
        halt_now_s     = 1'b0;
        instr_done_s   = 1'b0;
        instr_count_s  = instr_count_r;
        running_s      = 1'b0;

        case (state_r)
            IDLE: begin
                phase_s        = PH_NONE;
                halt_pending_s = 1'b0;
                // Load wins over exec, exec wins over step.
                if (bus.load_en) begin
                    pc_s = bus.load_addr;
                end else if (bus.exec) begin
                    state_s = RUN;
                    phase_s = PH_P0;
                end else if (bus.step) begin
                    state_s = STEP;
                    phase_s = PH_P0;
                end else begin
                    state_s = IDLE;
                end
            end

            RUN, STEP: begin
                // A halt raised in P4 must count at that same P4 edge.
                halt_now_s     = halt_pending_r | bus.halt_req;
                halt_pending_s = halt_now_s;
                case (phase_r)
                    PH_P0: phase_s = PH_P1;
                    PH_P1: phase_s = PH_P2;
                    PH_P2: phase_s = PH_P3;
                    PH_P3: begin
                        phase_s = PH_P4;
                        if (bus.pc_enable) begin
                            pc_s = bus.next_pc;
                        end else begin
                            pc_s = pc_r;
                        end
                    end
                    PH_P4: begin
                        instr_done_s  = 1'b1;
                        instr_count_s = instr_count_r + 16'd1;
                        if ((state_r == RUN) && !halt_now_s) begin
                            phase_s = PH_P0;
                        end else begin
                            state_s        = IDLE;
                            phase_s        = PH_NONE;
                            halt_pending_s = 1'b0;
                        end
                    end
                    default: begin
                        // Corrupted phase: drop back to a safe idle state.
                        state_s        = IDLE;
                        phase_s        = PH_NONE;
                        halt_pending_s = 1'b0;
                    end
                endcase
            end

            default: begin
                state_s        = IDLE;
                phase_s        = PH_NONE;
                halt_pending_s = 1'b0;
            end
        endcase

        if (state_s != IDLE) begin
            running_s = 1'b1;
        end else begin
            running_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Phase, PC, halt flag and instruction bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r        <= PH_NONE;
            pc_r           <= PC_RESET;
            halt_pending_r <= 1'b0;
            instr_done_r   <= 1'b0;
            instr_count_r  <= 16'h0000;
            running_r      <= 1'b0;
        end else begin
            phase_r        <= phase_s;
            pc_r           <= pc_s;
            halt_pending_r <= halt_pending_s;
            instr_done_r   <= instr_done_s;
            instr_count_r  <= instr_count_s;
            running_r      <= running_s;
        end
    end

    assign bus.phase       = phase_r;
    assign bus.pc          = pc_r;
    assign bus.from_adder  = pc_r + 12'd1;
    assign bus.running     = running_r;
    assign bus.instr_done  = instr_done_r;
    assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_phase_pc_unit.sv
// Bench for phase_pc_unit: directed scenarios plus a randomized run, all
// checked against an instruction-level reference model.
module tb_phase_pc_unit;

    localparam logic [11:0] PC_RST = 12'h000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: mode 0=idle 1=run 2=step, phase index 0..4.
    int          m_mode;
    int          m_ph;
    logic [11:0] m_pc;
    logic        m_hp;
    logic        m_done;
    logic [15:0] m_cnt;

    phase_pc_unit_if bus_if ();

    phase_pc_unit #(.PC_RESET(PC_RST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] exp_phase();
        if (m_mode == 0) return 5'b00000;
        return 5'(1 << m_ph);
    endfunction

    function automatic logic [11:0] exp_adder();
        return 12'((int'(m_pc) + 1) % 4096);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_pc = PC_RST; m_hp = 1'b0; m_done = 1'b0; m_cnt = 16'h0000;
    endtask

    // Advance the model over one clock edge using the inputs now on the bus.
    task automatic model_edge();
        logic hp;
        if (m_mode == 0) begin
            m_done = 1'b0;
            if (bus_if.load_en) m_pc = bus_if.load_addr;
            else if (bus_if.exec) begin m_mode = 1; m_ph = 0; end
            else if (bus_if.step) begin m_mode = 2; m_ph = 0; end
        end else begin
            hp     = m_hp || bus_if.halt_req;
            m_done = (m_ph == 4);
            if (m_ph == 3 && bus_if.pc_enable) m_pc = bus_if.next_pc;
            if (m_ph == 4) begin
                m_cnt = 16'((int'(m_cnt) + 1) % 65536);
                if (m_mode == 1 && !hp) m_ph = 0;
                else begin m_mode = 0; hp = 1'b0; end
            end else begin
                m_ph = m_ph + 1;
            end
            m_hp = hp;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_inc();
        bus_if.next_pc = m_pc + 12'd1;
        tick();
    endtask

    task automatic drive_idle();
        bus_if.exec = 1'b0; bus_if.step = 1'b0; bus_if.halt_req = 1'b0;
        bus_if.load_en = 1'b0; bus_if.load_addr = 12'h000;
        bus_if.next_pc = 12'h000; bus_if.pc_enable = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        #2;
        n_checks++; if (bus_if.phase !== 5'b00000) begin n_fail++; $display("FAIL reset_phase: got %b want 00000", bus_if.phase); end
        n_checks++; if (bus_if.pc !== PC_RST) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus_if.pc, PC_RST); end
        n_checks++; if (bus_if.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", bus_if.running); end
        n_checks++; if (bus_if.instr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus_if.instr_done); end
        n_checks++; if (bus_if.instr_count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h want 0000", bus_if.instr_count); end
        n_checks++; if (bus_if.from_adder !== 12'h001) begin n_fail++; $display("FAIL reset_adder: got %h want 001", bus_if.from_adder); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.pc_enable = 1'b1; bus_if.next_pc = 12'h7E7; bus_if.halt_req = 1'b1;
            tick();
            n_checks++; if (bus_if.phase !== 5'b00000 || bus_if.pc !== PC_RST) begin
                n_fail++; $display("FAIL idle_hold: got phase %b pc %h want 00000 %h", bus_if.phase, bus_if.pc, PC_RST); end
        end
        drive_idle();
    endtask

    task automatic test_run_sequence();
        // load, exec and step together: only the load happens
        bus_if.load_en = 1'b1; bus_if.load_addr = 12'h100; bus_if.exec = 1'b1; bus_if.step = 1'b1;
        tick();
        n_checks++; if (bus_if.pc !== 12'h100 || bus_if.phase !== 5'b00000 || bus_if.running !== 1'b0) begin
            n_fail++; $display("FAIL load_priority: got pc %h phase %b run %b want 100 00000 0", bus_if.pc, bus_if.phase, bus_if.running); end
        bus_if.load_en = 1'b0; bus_if.step = 1'b0;
        tick();
        bus_if.exec = 1'b0;
        n_checks++; if (bus_if.phase !== 5'b00001 || bus_if.running !== 1'b1) begin
            n_fail++; $display("FAIL exec_start: got phase %b run %b want 00001 1", bus_if.phase, bus_if.running); end
        bus_if.pc_enable = 1'b1;
        for (int c = 0; c < 15; c++) begin
            bus_if.exec = c[0]; bus_if.load_en = (c % 3 == 0); bus_if.load_addr = 12'hABC;
            tick_inc();
            n_checks++; if (bus_if.phase !== 5'(1 << ((c + 1) % 5))) begin
                n_fail++; $display("FAIL run_phase: cycle %0d got %b want %b", c, bus_if.phase, 5'(1 << ((c + 1) % 5))); end
            n_checks++; if (bus_if.instr_done !== (c % 5 == 4)) begin
                n_fail++; $display("FAIL run_done: cycle %0d got %b want %b", c, bus_if.instr_done, (c % 5 == 4)); end
            n_checks++; if (bus_if.pc !== m_pc) begin
                n_fail++; $display("FAIL run_pc: cycle %0d got %h want %h", c, bus_if.pc, m_pc); end
        end
        bus_if.exec = 1'b0; bus_if.load_en = 1'b0;
        n_checks++; if (bus_if.pc !== 12'h103 || bus_if.instr_count !== 16'd3) begin
            n_fail++; $display("FAIL run_total: got pc %h count %0d want 103 3", bus_if.pc, bus_if.instr_count); end
    endtask

    task automatic test_halt();
        tick_inc();
        bus_if.halt_req = 1'b1;
        tick_inc();
        bus_if.halt_req = 1'b0;
        for (int i = 0; i < 3; i++) tick_inc();
        n_checks++; if (bus_if.phase !== 5'b00000 || bus_if.running !== 1'b0 || bus_if.instr_done !== 1'b1) begin
            n_fail++; $display("FAIL halt_stop: got phase %b run %b done %b want 00000 0 1", bus_if.phase, bus_if.running, bus_if.instr_done); end
        n_checks++; if (bus_if.pc !== 12'h104 || bus_if.instr_count !== 16'd4) begin
            n_fail++; $display("FAIL halt_pc: got pc %h count %0d want 104 4", bus_if.pc, bus_if.instr_count); end
        tick_inc();
        n_checks++; if (bus_if.phase !== 5'b00000 || bus_if.instr_done !== 1'b0) begin
            n_fail++; $display("FAIL halt_idle: got phase %b done %b want 00000 0", bus_if.phase, bus_if.instr_done); end
        bus_if.exec = 1'b1;
        tick_inc();
        bus_if.exec = 1'b0;
        for (int i = 0; i < 4; i++) tick_inc();
        n_checks++; if (bus_if.phase !== 5'b10000 || bus_if.pc !== 12'h105) begin
            n_fail++; $display("FAIL resume: got phase %b pc %h want 10000 105", bus_if.phase, bus_if.pc); end
        bus_if.halt_req = 1'b1;
        tick_inc();
        bus_if.halt_req = 1'b0;
        n_checks++; if (bus_if.phase !== 5'b00000 || bus_if.running !== 1'b0 || bus_if.instr_count !== 16'd5) begin
            n_fail++; $display("FAIL halt_p4: got phase %b run %b count %0d want 00000 0 5", bus_if.phase, bus_if.running, bus_if.instr_count); end
    endtask

    task automatic test_step();
        apply_reset();
        bus_if.load_en = 1'b1; bus_if.load_addr = 12'h020;
        tick();
        bus_if.load_en = 1'b0; bus_if.step = 1'b1;
        tick();
        bus_if.step = 1'b0; bus_if.pc_enable = 1'b1; bus_if.next_pc = 12'h3A0;
        n_checks++; if (bus_if.phase !== 5'b00001 || bus_if.running !== 1'b1 || bus_if.pc !== 12'h020) begin
            n_fail++; $display("FAIL step_start: got phase %b run %b pc %h want 00001 1 020", bus_if.phase, bus_if.running, bus_if.pc); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus_if.pc !== 12'h3A0 || bus_if.phase !== 5'b00000 || bus_if.running !== 1'b0) begin
            n_fail++; $display("FAIL step_end: got pc %h phase %b run %b want 3A0 00000 0", bus_if.pc, bus_if.phase, bus_if.running); end
        n_checks++; if (bus_if.instr_count !== 16'd1 || bus_if.instr_done !== 1'b1) begin
            n_fail++; $display("FAIL step_count: got count %0d done %b want 1 1", bus_if.instr_count, bus_if.instr_done); end
        bus_if.next_pc = 12'h123;
        tick();
        n_checks++; if (bus_if.pc !== 12'h3A0 || bus_if.phase !== 5'b00000 || bus_if.instr_done !== 1'b0) begin
            n_fail++; $display("FAIL step_after: got pc %h phase %b done %b want 3A0 00000 0", bus_if.pc, bus_if.phase, bus_if.instr_done); end
        drive_idle();
    endtask

    task automatic test_wrap();
        bus_if.load_en = 1'b1; bus_if.load_addr = 12'hFFF;
        tick();
        bus_if.load_en = 1'b0;
        n_checks++; if (bus_if.from_adder !== 12'h000) begin
            n_fail++; $display("FAIL wrap_adder: got %h want 000", bus_if.from_adder); end
        bus_if.step = 1'b1;
        tick();
        bus_if.step = 1'b0; bus_if.pc_enable = 1'b1; bus_if.next_pc = 12'h000;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (bus_if.pc !== 12'h000 || bus_if.from_adder !== 12'h001) begin
            n_fail++; $display("FAIL wrap_pc: got pc %h adder %h want 000 001", bus_if.pc, bus_if.from_adder); end
        drive_idle();
    endtask

    task automatic test_async_reset();
        bus_if.load_en = 1'b1; bus_if.load_addr = 12'h055;
        tick();
        bus_if.load_en = 1'b0; bus_if.exec = 1'b1;
        tick();
        bus_if.exec = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        bus_if.pc_enable = 1'b1; bus_if.next_pc = 12'h0AA;
        n_checks++; if (bus_if.phase !== 5'b01000 || bus_if.pc !== 12'h055) begin
            n_fail++; $display("FAIL areset_setup: got phase %b pc %h want 01000 055", bus_if.phase, bus_if.pc); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus_if.pc !== PC_RST || bus_if.phase !== 5'b00000 || bus_if.running !== 1'b0 || bus_if.instr_count !== 16'h0000) begin
            n_fail++; $display("FAIL areset_now: got pc %h phase %b run %b count %h want %h 00000 0 0000", bus_if.pc, bus_if.phase, bus_if.running, bus_if.instr_count, PC_RST); end
        model_reset();
        drive_idle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (bus_if.instr_done !== 1'b0 || bus_if.pc !== PC_RST || bus_if.phase !== 5'b00000) begin
                n_fail++; $display("FAIL areset_after: got done %b pc %h phase %b want 0 %h 00000", bus_if.instr_done, bus_if.pc, bus_if.phase, PC_RST); end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            bus_if.exec      = ($urandom_range(0, 3) == 0);
            bus_if.step      = ($urandom_range(0, 5) == 0);
            bus_if.load_en   = ($urandom_range(0, 5) == 0);
            bus_if.halt_req  = ($urandom_range(0, 11) == 0);
            bus_if.pc_enable = 1'($urandom_range(0, 1));
            bus_if.load_addr = 12'($urandom_range(0, 4095));
            bus_if.next_pc   = 12'($urandom_range(0, 4095));
            tick();
            n_checks++; if (bus_if.phase !== exp_phase() || bus_if.pc !== m_pc || bus_if.from_adder !== exp_adder() ||
                            bus_if.running !== (m_mode != 0) || bus_if.instr_done !== m_done || bus_if.instr_count !== m_cnt) begin
                n_fail++;
                $display("FAIL random: cycle %0d got ph %b pc %h add %h run %b done %b cnt %h want ph %b pc %h add %h run %b done %b cnt %h",
                         c, bus_if.phase, bus_if.pc, bus_if.from_adder, bus_if.running, bus_if.instr_done, bus_if.instr_count,
                         exp_phase(), m_pc, exp_adder(), (m_mode != 0), m_done, m_cnt);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_run_sequence();
        test_halt();
        test_step();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_pc_unit.md
PHASE_PC_UNIT -- requirements
Module: phase_pc_unit

Parameters
REQ-001 PC_RESET, 12'h000, PC value after reset.

Interface
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 exec  in  1  start continuous run; level is sampled each cycle.
REQ-006 step  in  1  run exactly one instruction; level is sampled each cycle.
REQ-007 halt_req  in  1  stop after the current instruction, from decode.
REQ-008 load_en  in  1  load the PC from load_addr.
REQ-009 load_addr  in  12  PC load value.
REQ-010 next_pc  in  12  PC write value from the PC-select stage.
REQ-011 pc_enable  in  1  PC write enable from the PC-select stage.
REQ-012 phase  out  5  one-hot phase: P0=00001, P1=00010, P2=00100, P3=01000, P4=10000; idle=00000.
REQ-013 pc  out  12  current program counter.
REQ-014 from_adder  out  12  pc+1, combinational.
REQ-015 running  out  1  high in RUN or STEP.
REQ-016 instr_done  out  1  one-cycle pulse at completion of P4.
REQ-017 instr_count  out  16  count of completed instructions.

Function
REQ-018 FSM states SHALL be IDLE, RUN and STEP; phase SHALL be 00000 in IDLE and exactly one-hot otherwise.
REQ-019 In IDLE, priority SHALL be load_en > exec > step; the lower-priority inputs are ignored that cycle.
REQ-020 IDLE with load_en=1: pc SHALL take load_addr at the next edge; state stays IDLE.
REQ-021 IDLE with exec=1 (load_en=0) at edge t: state SHALL be RUN and phase P0 after edge t.
REQ-022 IDLE with step=1 (load_en=0, exec=0): state SHALL be STEP and phase P0 at the next edge.
REQ-023 In RUN/STEP, phase SHALL rotate P0->P1->P2->P3->P4, one per cycle.
REQ-024 In RUN/STEP, exec, step and load_en SHALL be ignored.
REQ-025 pc SHALL update to next_pc at the edge ending a cycle only when state is RUN/STEP, phase==P3 and pc_enable==1.
REQ-026 pc_enable SHALL be ignored in all other phases and in IDLE.
REQ-027 from_adder SHALL equal (pc+1) mod 4096; 12'hFFF SHALL yield 12'h000.
REQ-028 halt_req=1 in any RUN/STEP cycle SHALL set an internal halt_pending flag; halt_req SHALL be ignored in IDLE.
REQ-029 At the edge ending P4: RUN with halt_pending clear SHALL go to P0 and stay RUN.
REQ-030 At the edge ending P4: RUN with halt_pending set SHALL go to IDLE (phase 00000) and clear halt_pending.
REQ-031 At the edge ending P4: STEP SHALL go to IDLE regardless of halt_pending, and clear halt_pending.
REQ-032 halt_req asserted during P4 SHALL take effect at that same P4 edge.
REQ-033 instr_done SHALL be high for exactly the cycle following each P4 cycle.
REQ-034 instr_count SHALL increment at each P4 edge and wrap 16'hFFFF->16'h0000.
REQ-035 Latency: exec to first P3 SHALL be 4 cycles; each instruction SHALL take 5 cycles, with no bubbles between instructions in RUN.

Reset
REQ-036 rst=1 SHALL immediately, without waiting for clk, force: state IDLE, phase 00000, pc PC_RESET, halt_pending 0, instr_done 0, instr_count 0, running 0.
REQ-037 Reset mid-instruction SHALL abandon the instruction with no PC write and no instr_done pulse.
REQ-038 After rst deasserts, the block SHALL remain IDLE until exec or step.

Verification
REQ-039 Reset, then load_en with load_addr=12'h100, then exec, with pc_enable=1 and next_pc=from_adder in P3 -> phase sequence 00001,00010,00100,01000,10000 repeating; pc = 101, 102, 103 after successive P3 edges; instr_done pulses every 5 cycles.
REQ-040 step from pc=12'h020 with pc_enable=1 and next_pc=12'h3A0 -> one instruction only; pc=3A0; phase 00000 afterwards; instr_count=1; running low.
REQ-041 RUN with halt_req pulsed during P1 -> current instruction completes; IDLE after P4; later exec resumes from the updated pc.
REQ-042 pc=12'hFFF -> from_adder=12'h000; PC write of from_adder -> pc=000.
REQ-043 rst asserted asynchronously during P3 with pc_enable=1 -> pc=PC_RESET and phase=00000 immediately; no instr_done pulse.
REQ-044 In IDLE, load_en, exec and step in the same cycle -> only the load occurs; state stays IDLE. exec during RUN -> no effect.
